odo_sbox_small_seq: RTL and testbench
=====================================

// Module: odo_sbox_small_seq
// PURPOSE
//   Sequencer wrapped around one external odo_sbox_smallNN instance (registered, 1-cycle, no reset).
//   - Accepts a word of NCHUNK 6-bit chunks on a valid/ready input.
//   - Feeds the chunks to the S-box one per cycle and collects the substituted chunks.
//   - Presents the reassembled word on a valid/ready output.
//   - Sits directly upstream (sb_in) and downstream (sb_out) of the S-box. It is S-box-agnostic.
// PARAMETERS
//   NCHUNK  8  number of 6-bit chunks per word; word width W = 6*NCHUNK; NCHUNK >= 2
// PORTS
//   clk        in   1    single clock; all state on posedge
//   rst        in   1    reset, asynchronous, active-high
//   in_valid   in   1    upstream word valid
//   in_ready   out  1    block can accept a word
//   in_data    in   W    chunk i = in_data[6*i+5:6*i]
//   sb_in      out  6    address to S-box instance
//   sb_out     in   6    S-box registered output (mem[sb_in] from previous cycle)
//   out_valid  out  1    substituted word valid
//   out_ready  in   1    downstream accepts word
//   out_data   out  W    chunk i = sbox(in_data chunk i), same bit placement
// BEHAVIOUR
//   Reset values: state IDLE, cnt=0, cap_vld=0, word_q=0, out_data=0, out_valid=0, in_ready=1, sb_in=0.
//   FSM states and transitions:
//   - IDLE: in_ready=1. On in_valid&in_ready: word_q<=in_data, cnt<=0, go to FEED.
//   - FEED: sb_in = word_q[6*cnt+:6] (combinational from registers).
//     - cnt increments every cycle.
//     - cap_vld<=1 and cap_idx<=cnt, to mark the sb_out returned next cycle.
//     - After cnt==NCHUNK-1 go to DRAIN.
//   - Capture: when cap_vld=1, out_data[6*cap_idx+:6] <= sb_out. This applies in FEED and in DRAIN.
//   - DRAIN: one cycle that captures the last chunk. cap_vld<=0. Then go to DONE with out_valid<=1.
//   - DONE: out_valid=1, out_data held stable.
//     - On out_ready: out_valid<=0, go to IDLE.
//     - out_ready=0 stalls indefinitely with no change.
//   Timing:
//   - Latency: accept edge at cycle 0, chunk k on sb_in in cycle 1+k, out_valid high from cycle NCHUNK+2 (10 for NCHUNK=8).
//   - Throughput, no macro: one word per NCHUNK+3 cycles.
//   sb_in outside FEED: holds chunk 0 of word_q. The S-box output is ignored because cap_vld=0.
//   Handshake rules:
//   - in_ready is low in FEED/DRAIN/DONE. in_data is don't-care while in_ready=0.
//   - No output is dropped. out_data changes only in FEED/DRAIN captures, never while out_valid=1.
//   Reset mid-operation: in-flight word is discarded. cap_vld clears, so the stale sb_out is never captured.
//     First cycle after reset release: in_ready=1.
//   cnt width is clog2(NCHUNK) and never wraps past NCHUNK-1. No arithmetic beyond cnt increment.
// CONFIGURATION
//   ODO_SBOX_SEQ_BACK2BACK_EN
//   - Defined: in DONE, in_ready = out_ready.
//     - If out_ready & in_valid in the same cycle, the output retires and the new word is loaded.
//     - FSM goes DONE->FEED directly, skipping IDLE.
//     - Throughput becomes one word per NCHUNK+2 cycles.
//   - Undefined: in_ready=1 only in IDLE (behaviour above).
// TESTING (NCHUNK=8, S-box instance odo_sbox_small38)
//   1 in_data=0, out_ready=1 -> out_data=48'h514514514514, out_valid rises exactly 10 cycles after accept.
//   2 chunks i=i (0..7) -> out chunks 0..7 = 14,09,37,1c,15,03,12,35; sb_in sequence 0..7 on cycles 1..8.
//   3 word done, out_ready=0 for 5 cycles -> out_valid=1, out_data stable, in_ready=0; then retires in 1 cycle.
//   4 assert rst in FEED (cnt=3) -> out_valid=0, in_ready=1 after release; next word (all 6'h3f) -> all chunks 6'h0a.
//   5 in_valid held high, 3 words, out_ready=1 -> words accepted every 11 cycles (10 with ODO_SBOX_SEQ_BACK2BACK_EN).
//   6 reset asserted asynchronously between clock edges -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/odo_sbox_small_seq_if.sv
// Handshake bundle for odo_sbox_small_seq: word input, word output and the S-box address/data pair.
// The slave modport is the sequencer's view; the master modport is the surrounding system's view.
interface odo_sbox_small_seq_if #(
   parameter int NCHUNK = 8
);
   localparam int W = 6 * NCHUNK;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [5:0]   sb_in;
   logic [5:0]   sb_out;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   modport slave (
      input  in_valid,
      input  in_data,
      input  sb_out,
      input  out_ready,
      output in_ready,
      output sb_in,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      output sb_out,
      output out_ready,
      input  in_ready,
      input  sb_in,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/odo_sbox_small_seq.sv
// Chunk sequencer around one external registered 6-bit S-box: word in, chunks out one per cycle, word back.
// Optional macro ODO_SBOX_SEQ_BACK2BACK_EN lets DONE retire and accept a new word in the same cycle.
module odo_sbox_small_seq #(
   parameter int NCHUNK = 8
) (
   input  logic                clk,
   input  logic                rst,
   odo_sbox_small_seq_if.slave bus
);
   localparam int W  = 6 * NCHUNK;
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FEED  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_cap_idx;
   logic          r_cap_vld;
   logic [W-1:0]  r_word_q;
   logic [W-1:0]  r_out_data;
   logic          r_out_valid;

   logic          w_in_ready;
   logic          w_accept;
   logic [5:0]    w_sb_in;

   // Input readiness depends only on state (and on out_ready when DONE may hand over directly).
   always_comb begin
      w_in_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
         end
         S_DONE: begin
`ifdef ODO_SBOX_SEQ_BACK2BACK_EN
            w_in_ready = bus.out_ready;
`else
            w_in_ready = 1'b0;
`endif
         end
         default: begin
            w_in_ready = 1'b0;
         end
      endcase
   end

   assign w_accept = bus.in_valid & w_in_ready;

   // cnt is held at zero outside FEED, so the S-box address then sits on chunk 0 of word_q.
   assign w_sb_in = r_word_q[6 * int'(r_cnt) +: 6];

   // Sequencer state, chunk counter and latched input word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= CNT_ZERO;
         r_word_q    <= {W{1'b0}};
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_word_q <= bus.in_data;
                  r_cnt    <= CNT_ZERO;
                  r_state  <= S_FEED;
               end
            end
            S_FEED: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= CNT_ZERO;
                  r_state <= S_DRAIN;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_DRAIN: begin
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
`ifdef ODO_SBOX_SEQ_BACK2BACK_EN
                  if (bus.in_valid) begin
                     r_word_q <= bus.in_data;
                     r_cnt    <= CNT_ZERO;
                     r_state  <= S_FEED;
                  end else begin
                     r_state <= S_IDLE;
                  end
`else
                  r_state <= S_IDLE;
`endif
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_cnt       <= CNT_ZERO;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Capture tag: the S-box answers one cycle late, so remember which chunk was addressed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cap_vld <= 1'b0;
         r_cap_idx <= CNT_ZERO;
      end else begin
         case (r_state)
            S_FEED: begin
               r_cap_vld <= 1'b1;
               r_cap_idx <= r_cnt;
            end
            S_DRAIN: begin
               r_cap_vld <= 1'b0;
            end
            default: begin
               r_cap_vld <= 1'b0;
            end
         endcase
      end
   end

   // Reassembly of substituted chunks; only tagged S-box results are written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data <= {W{1'b0}};
      end else begin
         if (r_cap_vld) begin
            r_out_data[6 * int'(r_cap_idx) +: 6] <= bus.sb_out;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.sb_in     = w_sb_in;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_odo_sbox_small_seq.sv
// Self-checking bench for odo_sbox_small_seq with a table-driven registered S-box and a word-level model.
module tb_odo_sbox_small_seq;
   localparam int NCHUNK = 8;
   localparam int W      = 6 * NCHUNK;
`ifdef ODO_SBOX_SEQ_BACK2BACK_EN
   localparam int PERIOD = NCHUNK + 2;
`else
   localparam int PERIOD = NCHUNK + 3;
`endif

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   logic [5:0] sbox_tbl [64];

   always #5 clk = ~clk;

   odo_sbox_small_seq_if #(.NCHUNK(NCHUNK)) bus ();

   odo_sbox_small_seq #(.NCHUNK(NCHUNK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Registered lookup standing in for the external S-box instance (no reset).
   always @(posedge clk) bus.sb_out <= sbox_tbl[bus.sb_in];

   function automatic logic [W-1:0] model(input logic [W-1:0] d);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < NCHUNK; i++) r[6*i +: 6] = sbox_tbl[d[6*i +: 6]];
      return r;
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [W-1:0] d);
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = rand_word();
   endtask

   // Entered in cycle 1 after the accept edge; returns in the first cycle with out_valid high.
   task automatic collect(input logic [W-1:0] d);
      int cyc;
      cyc = 1;
      while (bus.out_valid !== 1'b1 && cyc < 40) begin
         if (cyc <= NCHUNK) chk("sb_in_seq", 64'(bus.sb_in), 64'(d[6*(cyc-1) +: 6]));
         chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
         @(negedge clk);
         cyc++;
      end
      chk("latency", 64'(cyc), 64'(NCHUNK + 2));
      chk("out_data", 64'(bus.out_data), 64'(model(d)));
   endtask

   initial begin
      logic [W-1:0] d;
      logic [W-1:0] snap;
      logic [W-1:0] q[$];
      int t[3];
      int cyc, acc, ret;
      bit pend;

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 64; i++) sbox_tbl[i] = 6'($urandom_range(0, 63));
      sbox_tbl[0]  = 6'h14; sbox_tbl[1] = 6'h09; sbox_tbl[2] = 6'h37; sbox_tbl[3] = 6'h1c;
      sbox_tbl[4]  = 6'h15; sbox_tbl[5] = 6'h03; sbox_tbl[6] = 6'h12; sbox_tbl[7] = 6'h35;
      sbox_tbl[63] = 6'h0a;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_sb_in", 64'(bus.sb_in), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

      // 1: all-zero word
      bus.out_ready = 1'b1;
      accept('0);
      collect('0);
      chk("t1_const", 64'(bus.out_data), 64'(48'h514514514514));
      @(negedge clk);
      chk("t1_retired", 64'(bus.out_valid), 64'd0);
      chk("t1_idle_ready", 64'(bus.in_ready), 64'd1);

      // 2: chunk i = i
      for (int i = 0; i < NCHUNK; i++) d[6*i +: 6] = 6'(i);
      accept(d);
      collect(d);
      chk("t2_const", 64'(bus.out_data),
          64'({6'h35, 6'h12, 6'h03, 6'h15, 6'h1c, 6'h37, 6'h09, 6'h14}));
      @(negedge clk);
      chk("t2_retired", 64'(bus.out_valid), 64'd0);

      // 3: output stall for 5 cycles, upstream pushing meanwhile
      bus.out_ready = 1'b0;
      d = rand_word();
      accept(d);
      collect(d);
      snap = bus.out_data;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.in_data = rand_word();
         @(negedge clk);
         chk("t3_hold_valid", 64'(bus.out_valid), 64'd1);
         chk("t3_hold_data", 64'(bus.out_data), 64'(snap));
         chk("t3_hold_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("t3_retired", 64'(bus.out_valid), 64'd0);
      chk("t3_idle_ready", 64'(bus.in_ready), 64'd1);

      // 4: reset while feeding chunk 3
      accept(rand_word());
      repeat (3) @(negedge clk);
      chk("t4_cnt3_addr_busy", 64'(bus.in_ready), 64'd0);
      rst = 1'b1;
      #1;
      chk("t4_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("t4_rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("t4_rst_sb_in", 64'(bus.sb_in), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t4_rel_in_ready", 64'(bus.in_ready), 64'd1);
      chk("t4_rel_out_valid", 64'(bus.out_valid), 64'd0);
      d = {NCHUNK{6'h3f}};
      accept(d);
      collect(d);
      chk("t4_const", 64'(bus.out_data), 64'(48'h28a28a28a28a));
      @(negedge clk);

      // 5: in_valid held high, three words, measure accept spacing
      q.delete();
      cyc = 0; acc = 0; ret = 0; pend = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = rand_word();
      while (ret < 3 && cyc < 200) begin
         if (bus.out_valid === 1'b1 && q.size() > 0) begin
            chk("t5_out_data", 64'(bus.out_data), 64'(model(q.pop_front())));
            ret++;
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && acc < 3) begin
            t[acc] = cyc;
            q.push_back(bus.in_data);
            acc++;
            pend = 1'b1;
         end
         @(negedge clk);
         cyc++;
         if (pend) begin
            pend = 1'b0;
            if (acc < 3) bus.in_data = rand_word();
            else bus.in_valid = 1'b0;
         end
      end
      chk("t5_retired", 64'(ret), 64'd3);
      chk("t5_gap01", 64'(t[1] - t[0]), 64'(PERIOD));
      chk("t5_gap12", 64'(t[2] - t[1]), 64'(PERIOD));
      @(negedge clk);

      // 6: asynchronous reset between clock edges while a word is held
      bus.out_ready = 1'b0;
      d = rand_word();
      accept(d);
      collect(d);
      chk("t6_pre_valid", 64'(bus.out_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_out_valid", 64'(bus.out_valid), 64'd0);
      chk("t6_async_in_ready", 64'(bus.in_ready), 64'd1);
      chk("t6_async_out_data", 64'(bus.out_data), 64'd0);
      chk("t6_async_sb_in", 64'(bus.sb_in), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 7: random words with random output stalls
      for (int k = 0; k < 4; k++) begin
         bus.out_ready = 1'b0;
         d = rand_word();
         accept(d);
         collect(d);
         snap = bus.out_data;
         for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
            @(negedge clk);
            chk("t7_hold_data", 64'(bus.out_data), 64'(snap));
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         chk("t7_retired", 64'(bus.out_valid), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
